peripheral_interrupt_controller: RTL and testbench
==================================================

Name: peripheral_interrupt_controller

Overview:
Parametrised peripheral interrupt front-end for the CSR unit. It captures NUM_INTER peripheral sources plus the memory-error interrupt, with per-source edge or level mode, and arbitrates among pending sources round-robin. Granted sources go into a circular cause FIFO of configurable depth, and the head cause is presented to the CSR with a p_int / p_int_read handshake. Lost edges are reported through a sticky overflow flag.

Parameters:
NUM_INTER, 52, number of peripheral interrupt sources (1..64)
QUEUE_DEPTH, 16, cause FIFO entries; power of two, >= 2
MEM_ERR_CAUSE, 12, mcause value for the memory-error interrupt
CAUSE_BASE, 13, mcause of source i is CAUSE_BASE + i

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_err_int  in  1  memory-error interrupt request
me_i_en  in  1  memory-error interrupt enable
interrupts  in  NUM_INTER  peripheral interrupt requests
i_enable  in  NUM_INTER  per-source enable
i_edge_mode  in  NUM_INTER  1 = rising-edge triggered, 0 = level triggered
p_int_read  in  1  CSR accepts the presented cause
csr_busy  in  1  CSR is servicing another trap; do not present
overflow_clr  in  1  clears overflow
p_int  out  1  cause valid to CSR
p_mcause  out  32  cause presented to CSR
queue_count  out  $clog2(QUEUE_DEPTH+1)  FIFO occupancy
overflow  out  1  sticky: an edge event was lost

Behaviour:
- Reset (asynchronous, reset_n low): p_int=0, p_mcause=0, queue_count=0, overflow=0. Head and tail pointers, all pending and in_queue bits, the sampled-previous input vector and rr_ptr all clear. State=IDLE.
- Reset while p_int=1: the presented entry is dropped, with no pop handshake.
- Source index NUM_INTER is the memory error, using mem_err_int, me_i_en and level mode.
- Pending set:
  - Level mode: in the cycle interrupts[i] & i_enable[i] & ~in_queue[i] & ~pending[i] holds.
  - Edge mode: on interrupts[i] & ~prev[i] & i_enable[i]. prev is registered every cycle.
- Lost edge: an edge event with pending[i]=1 or in_queue[i]=1 sets overflow. If overflow_clr is asserted in the same cycle, set wins.
- i_enable[i]=0 clears pending[i]. Entries already in the FIFO are kept.
- Arbitration:
  - Memory-error pending has absolute priority.
  - Otherwise grant the first pending index at or above rr_ptr, wrapping to 0.
  - On a peripheral grant g, rr_ptr <= g+1, wrapping at NUM_INTER. A memory-error grant leaves rr_ptr unchanged.
  - At most one enqueue per cycle.
- Enqueue (grant and queue_count<QUEUE_DEPTH), all in one cycle:
  - Write {source index} at the tail, tail+1 mod QUEUE_DEPTH.
  - Clear pending[g], set in_queue[g].
- Full: when queue_count==QUEUE_DEPTH there is no enqueue, even if a pop occurs that same cycle. Pending bits are held, so nothing is lost.
- Cause arithmetic: the stored index is zero-extended to 32 bits. Memory error gives MEM_ERR_CAUSE; source i gives CAUSE_BASE+i.
- Output FSM:
  - IDLE: if queue_count!=0 and ~csr_busy, then p_int<=1, p_mcause<=cause(head), go to PRESENT.
  - PRESENT with p_int_read: pop head (head+1), clear in_queue of the popped source, p_int<=0, go to IDLE.
  - PRESENT with csr_busy and no p_int_read: p_int<=0, go to IDLE. The entry is retained and re-presented later.
  - p_int_read and csr_busy together: the read wins.
  - p_int_read in IDLE is ignored.
- p_mcause holds its last value while p_int=0.
- Push and pop in the same cycle: queue_count is unchanged.
- Latency: a request high before edge E0 gives pending after E0, enqueue after E1, p_int=1 after E2 (FIFO empty, not busy). The minimum spacing between consecutive presentations is 2 cycles (PRESENT, then IDLE).

Test Plan:
- Level source 5 held high, CAUSE_BASE=13: p_int rises 3 edges after assertion with p_mcause=18. After p_int_read, source 5 re-enqueues exactly once more (in_queue gating, no flooding).
- Memory error and sources 0 and 3 asserted in the same cycle, rr_ptr=0: presentation order is 12, 13, 16.
- Round robin: sources 2 and 7 edge-triggered, re-pulsed after each service, rr_ptr advancing: grants alternate 2, 7, 2, 7; neither source starves.
- QUEUE_DEPTH=4, 6 edge sources pulsed together: queue_count saturates at 4 with no overflow. The remaining 2 enqueue after pops, and all 6 causes are delivered.
- Edge source pulsed twice while its entry is still queued: overflow=1. overflow_clr returns it to 0; overflow_clr together with a new lost edge keeps it at 1.
- csr_busy asserted in PRESENT: p_int drops and the same p_mcause is re-presented after busy falls. Reset_n asserted mid-PRESENT: p_int=0 and queue_count=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/peripheral_interrupt_controller_if.sv
// CSR-side handshake bundle for the peripheral interrupt controller.
// The controller (master) presents a cause. The CSR unit (slave) accepts it
// or signals that it is busy.
interface peripheral_interrupt_controller_if;
    logic        p_int;
    logic [31:0] p_mcause;
    logic        p_int_read;
    logic        csr_busy;

    modport master (
        output p_int,
        output p_mcause,
        input  p_int_read,
        input  csr_busy
    );

    modport slave (
        input  p_int,
        input  p_mcause,
        output p_int_read,
        output csr_busy
    );
endinterface

// File: rtl/peripheral_interrupt_controller.sv
// Peripheral interrupt front-end for the CSR unit.
// The block captures NUM_INTER peripheral sources plus the memory-error source,
// each in edge or level mode. The memory-error source is always level mode.
// Pending sources are arbitrated round-robin, with absolute priority for the
// memory error. Granted source indices are queued in a circular cause FIFO,
// and the head cause is presented to the CSR with a p_int / p_int_read
// handshake. An edge that arrives while its source is still pending or queued
// is lost, and it sets the sticky overflow flag.
module peripheral_interrupt_controller #(
    parameter int NUM_INTER     = 52,
    parameter int QUEUE_DEPTH   = 16,
    parameter int MEM_ERR_CAUSE = 12,
    parameter int CAUSE_BASE    = 13
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             mem_err_int,
    input  logic                             me_i_en,
    input  logic [NUM_INTER-1:0]             interrupts,
    input  logic [NUM_INTER-1:0]             i_enable,
    input  logic [NUM_INTER-1:0]             i_edge_mode,
    input  logic                             overflow_clr,
    peripheral_interrupt_controller_if.master csr,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
    output logic                             overflow
);
    // Source NUM_INTER is the memory error. Indices below it are peripherals.
    localparam int NUM_SRC = NUM_INTER + 1;
    localparam int IDX_W   = $clog2(NUM_SRC);
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);

    localparam logic [IDX_W-1:0] MEM_IDX     = IDX_W'(NUM_INTER);
    localparam logic [IDX_W-1:0] LAST_PERIPH = IDX_W'(NUM_INTER - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    // Unified per-source views, with the memory error in the top bit.
    logic [NUM_SRC-1:0]   src_req;
    logic [NUM_SRC-1:0]   src_en;
    logic [NUM_SRC-1:0]   src_edge;

    logic [NUM_INTER-1:0] prev_q;
    logic [NUM_SRC-1:0]   pending_q;
    logic [NUM_SRC-1:0]   pending_d;
    logic [NUM_SRC-1:0]   in_queue_q;
    logic [NUM_SRC-1:0]   in_queue_d;
    logic [NUM_SRC-1:0]   edge_evt;
    logic [NUM_SRC-1:0]   level_set;
    logic [NUM_SRC-1:0]   lost_evt;

    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;

    logic [IDX_W-1:0]     fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [IDX_W-1:0]     head_idx;
    logic                 do_push;
    logic                 do_pop;

    state_t               state_q;
    state_t               state_d;
    logic                 p_int_d;
    logic [31:0]          mcause_d;

    // The memory error is a level source with its own enable.
    assign src_req  = {mem_err_int, interrupts};
    assign src_en   = {me_i_en, i_enable};
    assign src_edge = {1'b0, i_edge_mode};

    // Map a stored source index to its mcause value (zero-extended index).
    function automatic logic [31:0] cause_of(input logic [IDX_W-1:0] idx);
        if (idx == MEM_IDX) begin
            return 32'(MEM_ERR_CAUSE);
        end
        return 32'(CAUSE_BASE) + 32'(idx);
    endfunction

    // Classify this cycle's request activity per source.
    always_comb begin
        edge_evt  = src_req & src_en & src_edge & ~{1'b0, prev_q};
        level_set = src_req & src_en & ~src_edge & ~in_queue_q & ~pending_q;
        lost_evt  = edge_evt & (pending_q | in_queue_q);
    end

    // Arbiter: the memory error first, otherwise the first pending peripheral
    // at or above rr_ptr, wrapping to 0.
    // NOTE: every output of a combinational block is assigned a default at the
    // top, so no path leaves a value held, and no latch is inferred.
    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (pending_q[NUM_INTER]) begin
            grant_valid = 1'b1;
            grant_idx   = MEM_IDX;
        end else begin
            for (int k = 0; k < NUM_INTER; k++) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NUM_INTER) begin
                    cand = cand - NUM_INTER;
                end
                if (!grant_valid && pending_q[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(cand);
                end
            end
        end
    end

    // When the FIFO is full, pending bits simply wait. A same-cycle pop does
    // not make room.
    assign do_push  = grant_valid && (queue_count != FULL_COUNT);
    assign head_idx = fifo_mem[head_q];
    assign do_pop   = (state_q == PRESENT) && csr.p_int_read;

    // Next pending / in_queue. A lost edge is not recorded. Disabling a source
    // drops its pending bit but keeps its queued entry.
    always_comb begin
        pending_d  = (pending_q & src_en) | level_set
                   | (edge_evt & ~pending_q & ~in_queue_q);
        in_queue_d = in_queue_q;
        if (do_pop) begin
            in_queue_d[head_idx] = 1'b0;
        end
        if (do_push) begin
            pending_d[grant_idx]  = 1'b0;
            in_queue_d[grant_idx] = 1'b1;
        end
    end

    // Output FSM: present the head cause, then leave on read or busy.
    // The read wins when both are asserted.
    always_comb begin
        state_d  = state_q;
        p_int_d  = csr.p_int;
        mcause_d = csr.p_mcause;
        unique case (state_q)
            IDLE: begin
                if ((queue_count != '0) && !csr.csr_busy) begin
                    state_d  = PRESENT;
                    p_int_d  = 1'b1;
                    mcause_d = cause_of(head_idx);
                end
            end
            PRESENT: begin
                if (csr.p_int_read || csr.csr_busy) begin
                    state_d = IDLE;
                    p_int_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                p_int_d = 1'b0;
            end
        endcase
    end

    // Control state, pointers, flags and the CSR-facing output registers.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the clock edge, whatever the statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            csr.p_int    <= 1'b0;
            csr.p_mcause <= '0;
            queue_count  <= '0;
            overflow     <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            pending_q    <= '0;
            in_queue_q   <= '0;
            prev_q       <= '0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            csr.p_int    <= p_int_d;
            csr.p_mcause <= mcause_d;
            pending_q    <= pending_d;
            in_queue_q   <= in_queue_d;
            prev_q       <= interrupts;

            if (|lost_evt) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end

            if (do_push) begin
                tail_q <= tail_q + PTR_W'(1);
                if (grant_idx != MEM_IDX) begin
                    rr_ptr_q <= (grant_idx == LAST_PERIPH) ? '0 : grant_idx + IDX_W'(1);
                end
            end
            if (do_pop) begin
                head_q <= head_q + PTR_W'(1);
            end

            case ({do_push, do_pop})
                2'b10:   queue_count <= queue_count + CNT_W'(1);
                2'b01:   queue_count <= queue_count - CNT_W'(1);
                default: queue_count <= queue_count;
            endcase
        end
    end

    // Cause FIFO storage: only the tail slot is written, on an enqueue.
    // NOTE: the storage array has no reset. The occupancy and pointers decide
    // which slots are valid, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[tail_q] <= grant_idx;
        end
    end
endmodule

// File: tb/tb_peripheral_interrupt_controller.sv
// Scoreboard bench for peripheral_interrupt_controller (QUEUE_DEPTH = 4).
// Stimulus pushes the expected causes. A monitor pops one expected cause and
// compares it at each accepted p_int / p_int_read handshake.
module tb_peripheral_interrupt_controller;
    localparam int NUM_INTER = 52;
    localparam int QD        = 4;
    localparam int MEM_CAUSE = 12;
    localparam int BASE      = 13;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 mem_err_int;
    logic                 me_i_en;
    logic [NUM_INTER-1:0] interrupts;
    logic [NUM_INTER-1:0] i_enable;
    logic [NUM_INTER-1:0] i_edge_mode;
    logic                 overflow_clr;
    logic [2:0]           queue_count;
    logic                 overflow;

    peripheral_interrupt_controller_if csr_if ();

    peripheral_interrupt_controller #(
        .NUM_INTER    (NUM_INTER),
        .QUEUE_DEPTH  (QD),
        .MEM_ERR_CAUSE(MEM_CAUSE),
        .CAUSE_BASE   (BASE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_err_int (mem_err_int),
        .me_i_en     (me_i_en),
        .interrupts  (interrupts),
        .i_enable    (i_enable),
        .i_edge_mode (i_edge_mode),
        .overflow_clr(overflow_clr),
        .csr         (csr_if),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    bit          auto_read = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NUM_INTER-1:0] bit_of(input int i);
        logic [NUM_INTER-1:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    // CSR responder: accepts a presented cause one cycle after seeing it.
    always @(posedge clk) begin
        #2;
        csr_if.p_int_read = auto_read && csr_if.p_int;
    end

    // Monitor: each handshake pops one expected cause.
    always @(negedge clk) begin
        #1;
        if (reset_n && csr_if.p_int && csr_if.p_int_read) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cause", csr_if.p_mcause, 32'hFFFF_FFFF);
            end else begin
                check("cause_order", csr_if.p_mcause, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [NUM_INTER-1:0] mask);
        interrupts = interrupts | mask;
        @(negedge clk);
        interrupts = interrupts & ~mask;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n          = 1'b0;
        interrupts       = '0;
        i_enable         = '0;
        i_edge_mode      = '0;
        mem_err_int      = 1'b0;
        me_i_en          = 1'b0;
        overflow_clr     = 1'b0;
        csr_if.csr_busy  = 1'b0;
        auto_read        = 1'b0;
        exp_q.delete();
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_p_int(input string name, output int cyc);
        cyc = 0;
        while (!csr_if.p_int && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) begin
            check({name, "_p_int_timeout"}, 32'(csr_if.p_int), 32'd1);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (k < 200 && !(exp_q.size() == 0 && queue_count == 0 && !csr_if.p_int)) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drained"}, 32'(k < 200), 32'd1);
        tick(4);
        auto_read = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int k;

        // ---- Asynchronous reset state ----
        reset_n             = 1'b1;
        interrupts          = '0;
        i_enable            = '0;
        i_edge_mode         = '0;
        mem_err_int         = 1'b0;
        me_i_en             = 1'b0;
        overflow_clr        = 1'b0;
        csr_if.csr_busy     = 1'b0;
        csr_if.p_int_read   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_p_int", 32'(csr_if.p_int), 32'd0);
        check("rst_p_mcause", csr_if.p_mcause, 32'd0);
        check("rst_queue_count", 32'(queue_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        apply_reset();

        // ---- Level source 5: latency, cause 18, a single re-enqueue ----
        i_enable[5] = 1'b1;
        interrupts[5] = 1'b1;
        wait_p_int("lvl", cyc);
        check("lvl_latency", 32'(cyc), 32'd3);
        check("lvl_first_cause", csr_if.p_mcause, 32'd18);
        check("lvl_no_flood", 32'(queue_count), 32'd1);
        exp_q.push_back(32'd18);
        exp_q.push_back(32'd18);
        auto_read = 1'b1;
        k = 0;
        while (csr_if.p_int && k < 20) begin
            @(negedge clk);
            k++;
        end
        tick(1);
        interrupts[5] = 1'b0;
        drain("lvl");

        // ---- Memory error has priority, then round-robin from 0 ----
        apply_reset();
        me_i_en        = 1'b1;
        i_enable[0]    = 1'b1;
        i_enable[3]    = 1'b1;
        i_edge_mode[0] = 1'b1;
        i_edge_mode[3] = 1'b1;
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd13);
        exp_q.push_back(32'd16);
        auto_read   = 1'b1;
        mem_err_int = 1'b1;
        pulse(bit_of(0) | bit_of(3));
        mem_err_int = 1'b0;
        drain("prio");

        // ---- Round robin with sources 2 and 7 re-pulsed ----
        apply_reset();
        i_enable[2]    = 1'b1;
        i_enable[7]    = 1'b1;
        i_edge_mode[2] = 1'b1;
        i_edge_mode[7] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(32'd15);
            exp_q.push_back(32'd20);
            auto_read = 1'b1;
            pulse(bit_of(2) | bit_of(7));
            drain("rr");
        end

        // ---- Full FIFO: six edge sources into four entries ----
        apply_reset();
        begin
            int srcs[6] = '{1, 4, 9, 20, 33, 51};
            logic [NUM_INTER-1:0] m;
            m = '0;
            foreach (srcs[j]) begin
                m = m | bit_of(srcs[j]);
            end
            i_enable    = m;
            i_edge_mode = m;
            pulse(m);
            tick(8);
            check("full_count", 32'(queue_count), 32'd4);
            check("full_no_overflow", 32'(overflow), 32'd0);
            foreach (srcs[j]) begin
                exp_q.push_back(32'(BASE + srcs[j]));
            end
            auto_read = 1'b1;
            drain("full");
            check("full_no_overflow_end", 32'(overflow), 32'd0);
        end

        // ---- Lost edges and overflow_clr ----
        apply_reset();
        i_enable[10]    = 1'b1;
        i_edge_mode[10] = 1'b1;
        pulse(bit_of(10));
        tick(4);
        check("ovf_initial", 32'(overflow), 32'd0);
        pulse(bit_of(10));
        check("ovf_set", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        overflow_clr = 1'b1;
        pulse(bit_of(10));
        overflow_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        tick(2);
        check("ovf_sticky", 32'(overflow), 32'd1);
        exp_q.push_back(32'd23);
        auto_read = 1'b1;
        drain("ovf");

        // ---- csr_busy while presenting ----
        apply_reset();
        i_enable[6]    = 1'b1;
        i_edge_mode[6] = 1'b1;
        pulse(bit_of(6));
        wait_p_int("busy", cyc);
        check("busy_first_cause", csr_if.p_mcause, 32'd19);
        csr_if.csr_busy = 1'b1;
        tick(1);
        check("busy_p_int_drop", 32'(csr_if.p_int), 32'd0);
        tick(3);
        check("busy_hold_low", 32'(csr_if.p_int), 32'd0);
        check("busy_mcause_hold", csr_if.p_mcause, 32'd19);
        check("busy_retained", 32'(queue_count), 32'd1);
        csr_if.csr_busy = 1'b0;
        exp_q.push_back(32'd19);
        auto_read = 1'b1;
        drain("busy");

        // ---- Reset asserted mid-presentation ----
        apply_reset();
        i_enable[8]    = 1'b1;
        i_edge_mode[8] = 1'b1;
        pulse(bit_of(8));
        wait_p_int("midrst", cyc);
        check("midrst_pre_count", 32'(queue_count), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_p_int", 32'(csr_if.p_int), 32'd0);
        check("midrst_count", 32'(queue_count), 32'd0);
        check("midrst_mcause", csr_if.p_mcause, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(5);
        check("midrst_dropped", 32'(csr_if.p_int), 32'd0);
        check("midrst_empty", 32'(queue_count), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
